// File: rtl/park_pkg.sv
// Shared types and constants for the car-park entry gate controller.
package park_pkg;

  typedef enum logic [2:0] {
    Idle         = 3'd0,
    WaitPassword = 3'd1,
    WrongPass    = 3'd2,
    RightPass    = 3'd3,
    Stop         = 3'd4
  } park_state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  localparam logic [1:0] DEF_PASS_1 = 2'b01;
  localparam logic [1:0] DEF_PASS_2 = 2'b10;

endpackage

// File: rtl/park_controller_if.sv
// Gate sensors/keypad inputs and front-panel indicator outputs of the controller.
interface park_controller_if;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  // Panel/keypad side drives sensors and password, observes indicators.
  modport master (
    output sensor_entrance, sensor_exit, password_1, password_2,
    input  GREEN_LED, RED_LED, HEX_1, HEX_2
  );

  modport slave (
    input  sensor_entrance, sensor_exit, password_1, password_2,
    output GREEN_LED, RED_LED, HEX_1, HEX_2
  );
endinterface

// File: rtl/park_controller.sv
// Car-park entry gate Moore FSM: settling wait, password check, registered LED/7-seg outputs.
module park_controller
  import park_pkg::*;
#(
  parameter logic [1:0]  PASS_1      = DEF_PASS_1,
  parameter logic [1:0]  PASS_2      = DEF_PASS_2,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  park_controller_if.slave bus
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);

  park_state_e     state_q, state_d;
  park_state_e     out_state_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            green_q, green_d;
  logic            red_q, red_d;
  logic [6:0]      hex1_q, hex1_d;
  logic [6:0]      hex2_q, hex2_d;
  logic            pass_ok;

  assign pass_ok = (bus.password_1 == PASS_1) && (bus.password_2 == PASS_2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      Idle: begin
        if (bus.sensor_entrance) state_d = WaitPassword;
      end
      WaitPassword: begin
        if (cnt_q == CntMax) begin
          state_d = pass_ok ? RightPass : WrongPass;
          cnt_d   = cnt_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WrongPass: begin
        if (pass_ok) state_d = RightPass;
      end
      RightPass: begin
        if (bus.sensor_entrance && bus.sensor_exit) state_d = Stop;
        else if (bus.sensor_exit)                   state_d = Idle;
      end
      Stop: begin
        if (pass_ok) state_d = RightPass;
      end
      default: state_d = Idle;
    endcase
  end

  // A blinking LED restarts at 1 whenever the displayed state was something else.
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = SEG_BLANK;
    hex2_d  = SEG_BLANK;
    case (state_q)
      WaitPassword: begin
        red_d  = 1'b1;
        hex1_d = SEG_E;
        hex2_d = SEG_N;
      end
      WrongPass: begin
        red_d  = !((out_state_q == WrongPass) && red_q);
        hex1_d = SEG_E;
        hex2_d = SEG_E;
      end
      RightPass: begin
        green_d = !((out_state_q == RightPass) && green_q);
        hex1_d  = SEG_G;
        hex2_d  = SEG_O;
      end
      Stop: begin
        red_d  = !((out_state_q == Stop) && red_q);
        hex1_d = SEG_S;
        hex2_d = SEG_P;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_state_q <= Idle;
      green_q     <= 1'b0;
      red_q       <= 1'b0;
      hex1_q      <= SEG_BLANK;
      hex2_q      <= SEG_BLANK;
    end else begin
      out_state_q <= state_q;
      green_q     <= green_d;
      red_q       <= red_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
    end
  end

  assign bus.GREEN_LED = green_q;
  assign bus.RED_LED   = red_q;
  assign bus.HEX_1     = hex1_q;
  assign bus.HEX_2     = hex2_q;

endmodule

// File: tb/tb_park_controller.sv
// Directed self-checking bench for park_controller.
module tb_park_controller;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] HE = 7'b0000110;
  localparam logic [6:0] HN = 7'b0101011;
  localparam logic [6:0] HG = 7'b0000010;
  localparam logic [6:0] HO = 7'b1000000;
  localparam logic [6:0] HS = 7'b0010010;
  localparam logic [6:0] HP = 7'b0001100;

  // Expected output vectors {GREEN, RED, HEX_1, HEX_2}
  localparam logic [15:0] V_BLANK = {1'b0, 1'b0, BL, BL};
  localparam logic [15:0] V_EN    = {1'b0, 1'b1, HE, HN};
  localparam logic [15:0] V_GO1   = {1'b1, 1'b0, HG, HO};
  localparam logic [15:0] V_GO0   = {1'b0, 1'b0, HG, HO};
  localparam logic [15:0] V_EE1   = {1'b0, 1'b1, HE, HE};
  localparam logic [15:0] V_EE0   = {1'b0, 1'b0, HE, HE};
  localparam logic [15:0] V_SP1   = {1'b0, 1'b1, HS, HP};
  localparam logic [15:0] V_SP0   = {1'b0, 1'b0, HS, HP};

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  park_controller_if bus ();

  park_controller #(
    .PASS_1     (2'b01),
    .PASS_2     (2'b10),
    .WAIT_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {bus.GREEN_LED, bus.RED_LED, bus.HEX_1, bus.HEX_2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pw(input logic [1:0] p1, input logic [1:0] p2);
    bus.password_1 = p1;
    bus.password_2 = p2;
  endtask

  // Applies one tick per entry of exp and compares outputs after each edge.
  task automatic run_seq(input string name, input logic [15:0] exp[]);
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      total++;
      if (obs() !== exp[i]) begin
        bad++;
        $display("FAIL %s step %0d: got=%h expected=%h", name, i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sensor_entrance = i[0];
      bus.sensor_exit     = ~i[0];
      set_pw(2'b01, 2'b10);
      tick();
      total++;
      if (obs() !== V_BLANK) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got=%h expected=%h", i, obs(), V_BLANK);
      end
    end
    bus.sensor_entrance = 1'b0;
    bus.sensor_exit     = 1'b0;
    set_pw(2'b00, 2'b00);
    reset_n = 1'b1;
    run_seq("reset_release_idle", '{V_BLANK, V_BLANK});
  endtask

  task automatic test_correct_entry();
    set_pw(2'b01, 2'b10);
    bus.sensor_entrance = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    total++;
    if (obs() !== V_BLANK) begin
      bad++;
      $display("FAIL entry_lag: got=%h expected=%h", obs(), V_BLANK);
    end
    run_seq("correct_wait", '{V_EN, V_EN, V_EN, V_EN, V_EN});
    run_seq("correct_blink", '{V_GO1, V_GO0, V_GO1});
    bus.sensor_exit = 1'b1;
    tick();
    bus.sensor_exit = 1'b0;
    run_seq("correct_exit", '{V_BLANK, V_BLANK});
  endtask

  task automatic test_wrong_password();
    set_pw(2'b11, 2'b00);
    bus.sensor_entrance = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    run_seq("wrong_wait", '{V_EN, V_EN, V_EN, V_EN, V_EN});
    run_seq("wrong_blink", '{V_EE1, V_EE0, V_EE1});
    set_pw(2'b01, 2'b10);
    run_seq("wrong_recover", '{V_EE0, V_GO1});
  endtask

  task automatic test_tailgate();
    // Already in RIGHT_PASS with GREEN=1 shown
    set_pw(2'b00, 2'b00);
    bus.sensor_entrance = 1'b1;
    bus.sensor_exit     = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    bus.sensor_exit     = 1'b0;
    total++;
    if (obs() !== V_GO0) begin
      bad++;
      $display("FAIL tailgate_lag: got=%h expected=%h", obs(), V_GO0);
    end
    run_seq("tailgate_stop", '{V_SP1, V_SP0, V_SP1, V_SP0});
    set_pw(2'b01, 2'b10);
    run_seq("tailgate_resume", '{V_SP1, V_GO1, V_GO0});
    bus.sensor_exit = 1'b1;
    tick();
    bus.sensor_exit = 1'b0;
    run_seq("tailgate_exit", '{V_BLANK});
  endtask

  task automatic test_pw_change_in_wait();
    set_pw(2'b11, 2'b00);
    bus.sensor_entrance = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    run_seq("late_ok_wait", '{V_EN, V_EN, V_EN, V_EN});
    set_pw(2'b01, 2'b10);
    run_seq("late_ok_eval", '{V_EN, V_GO1});
    bus.sensor_exit = 1'b1;
    run_seq("late_ok_exit", '{V_GO0, V_BLANK});
    bus.sensor_exit = 1'b0;
    // Correct early, wrong at the evaluation edge
    bus.sensor_entrance = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    run_seq("late_bad_wait", '{V_EN, V_EN, V_EN, V_EN});
    set_pw(2'b01, 2'b11);
    run_seq("late_bad_eval", '{V_EN, V_EE1});
    set_pw(2'b01, 2'b10);
    bus.sensor_exit = 1'b1;
    run_seq("late_bad_exit", '{V_EE0, V_GO1, V_BLANK});
    bus.sensor_exit = 1'b0;
  endtask

  task automatic test_idle_robust();
    set_pw(2'b01, 2'b10);
    bus.sensor_exit = 1'b1;
    run_seq("idle_robust", '{V_BLANK, V_BLANK, V_BLANK});
    bus.sensor_exit = 1'b0;
  endtask

  task automatic test_async_reset_mid();
    set_pw(2'b01, 2'b10);
    bus.sensor_entrance = 1'b1;
    tick();
    bus.sensor_entrance = 1'b0;
    run_seq("mid_reset_setup", '{V_EN, V_EN, V_EN, V_EN, V_EN, V_GO1});
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs() !== V_BLANK) begin
      bad++;
      $display("FAIL async_reset_clear: got=%h expected=%h", obs(), V_BLANK);
    end
    tick();
    reset_n = 1'b1;
    run_seq("after_mid_reset", '{V_BLANK, V_BLANK});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    bus.sensor_entrance = 1'b0;
    bus.sensor_exit     = 1'b0;
    set_pw(2'b00, 2'b00);
    test_reset();
    test_correct_entry();
    test_wrong_password();
    test_tailgate();
    test_pw_change_in_wait();
    test_idle_robust();
    test_async_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
